// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_arb_pkg : shared types for the two-master data-memory port arbiter   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam logic M_LOADER = 1'b0;
  localparam logic M_CPU    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arb2_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | arb2_pick : combinational winner select between the loader and the CPU   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module arb2_pick
  import mem_arb_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  always_comb begin
    winner = M_LOADER;
    case (req)
      2'b10:   winner = M_CPU;
      // Contention: alternate away from the last served master, or favour the loader.
      2'b11:   winner = ROUND_ROBIN ? ~last : M_LOADER;
      default: winner = M_LOADER;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter : serialises two stall-handshake masters onto one slave |
// | Revision         : 1.0                                                   |
// +--------------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_en,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wd,
  output logic [DATA_W-1:0] m0_rd,
  output logic              m0_stall,
  input  logic              m1_en,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wd,
  output logic [DATA_W-1:0] m1_rd,
  output logic              m1_stall,
  output logic              s_en,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wd,
  input  logic [DATA_W-1:0] s_rd,
  input  logic              s_stall,
  output logic              grant,
  output logic              timeout
);

  localparam int unsigned     CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

  arb_state_t        state_q, state_d;
  logic              s_we_q, s_we_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wd_q, s_wd_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              w_winner;

  arb2_pick #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_pick (
    .req    ({m1_en, m0_en}),
    .last   (last_q),
    .winner (w_winner)
  );

  always_comb begin
    state_d    = state_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wd_d     = s_wd_q;
    rd_d       = rd_q;
    grant_d    = grant_q;
    last_d     = last_q;
    timeout_d  = timeout_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (m0_en || m1_en) begin
          grant_d  = w_winner;
          s_we_d   = (w_winner == M_CPU) ? m1_we   : m0_we;
          s_addr_d = (w_winner == M_CPU) ? m1_addr : m0_addr;
          s_wd_d   = (w_winner == M_CPU) ? m1_wd   : m0_wd;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (!s_stall) begin
          wait_cnt_d = '0;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (!s_stall) begin
          rd_d    = s_rd;
          state_d = DONE;
        end else if (wait_cnt_q != c_timeout) begin
          // Saturates at the bound; with TIMEOUT=0 it is already saturated and never flags.
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_d == c_timeout) timeout_d = 1'b1;
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wd_q     <= '0;
      rd_q       <= '0;
      grant_q    <= M_LOADER;
      last_q     <= M_CPU;
      timeout_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wd_q     <= s_wd_d;
      rd_q       <= rd_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign s_en     = (state_q == ISSUE);
  assign s_we     = s_we_q;
  assign s_addr   = s_addr_q;
  assign s_wd     = s_wd_q;
  assign grant    = grant_q;
  assign timeout  = timeout_q;
  assign m0_rd    = rd_q;
  assign m1_rd    = rd_q;
  assign m0_stall = m0_en & ~((state_q == DONE) & (grant_q == M_LOADER));
  assign m1_stall = m1_en & ~((state_q == DONE) & (grant_q == M_CPU));

endmodule
`default_nettype wire
